// File: rtl/button_conditioner.sv
// Input conditioning for the SLC-3 top level: two-flop sync on every input,
// counter debounce plus one-cycle press pulses on the active-low buttons.
// Optional macro CONT_AUTOREPEAT_EN adds periodic Continue pulses while held.

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000,
  parameter bit AUTOREPEAT      = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_n,
  output logic       level_n,
  output logic       pulse,
  output logic [1:0] state_dbg
);
  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] S_RELEASED     = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  logic [1:0]    sync_q, sync_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic          press;
  logic          rep_fire;
  logic          sync;

  assign sync = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], raw_n};
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press   = 1'b0;
    case (state_q)
      S_RELEASED: begin
        if (!sync) begin
          state_d = S_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (sync) begin
          state_d = S_RELEASED;
        end else if (cnt_q == DB_LAST) begin
          state_d = S_PRESSED;
          level_d = 1'b0;
          press   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PRESSED: begin
        if (sync) begin
          state_d = S_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      default: begin
        // A low sample during release-wait is bounce: back to PRESSED, no pulse.
        if (!sync) begin
          state_d = S_PRESSED;
        end else if (cnt_q == DB_LAST) begin
          state_d = S_RELEASED;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
    pulse_d = press | rep_fire;
  end

  generate
    if (AUTOREPEAT) begin : g_rep
      localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
      logic [CW-1:0] rep_q, rep_d;
      // Counter only runs while staying in PRESSED, so every entry restarts it.
      always_comb begin
        rep_d    = '0;
        rep_fire = 1'b0;
        if (state_q == S_PRESSED && state_d == S_PRESSED) begin
          if (rep_q == REP_LAST) rep_fire = 1'b1;
          else                   rep_d    = rep_q + 1'b1;
        end
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep_q <= '0;
        else        rep_q <= rep_d;
      end
    end else begin : g_norep
      assign rep_fire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= S_RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_n   = level_q;
  assign pulse     = pulse_q;
  assign state_dbg = state_q;
endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 25000000,
  parameter int SW_WIDTH        = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Run_raw,
  input  logic                Continue_raw,
  input  logic [SW_WIDTH-1:0] S_raw,
  output logic                Run_n,
  output logic                Continue_n,
  output logic                Run_pulse,
  output logic                Continue_pulse,
  output logic [SW_WIDTH-1:0] S_sync,
  output logic [1:0]          run_state_dbg,
  output logic [1:0]          cont_state_dbg
);
`ifdef CONT_AUTOREPEAT_EN
  localparam bit CONT_REPEAT = 1'b1;
`else
  localparam bit CONT_REPEAT = 1'b0;
`endif

  logic [SW_WIDTH-1:0] sw_meta_q, sw_meta_d;
  logic [SW_WIDTH-1:0] sw_sync_q, sw_sync_d;

  always_comb begin
    sw_meta_d = S_raw;
    sw_sync_d = sw_meta_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  assign S_sync = sw_sync_q;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .AUTOREPEAT     (1'b0)
  ) u_run (
    .clk      (Clk),
    .rst_n    (Reset),
    .raw_n    (Run_raw),
    .level_n  (Run_n),
    .pulse    (Run_pulse),
    .state_dbg(run_state_dbg)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_CYCLES  (REPEAT_CYCLES),
    .AUTOREPEAT     (CONT_REPEAT)
  ) u_cont (
    .clk      (Clk),
    .rst_n    (Reset),
    .raw_n    (Continue_raw),
    .level_n  (Continue_n),
    .pulse    (Continue_pulse),
    .state_dbg(cont_state_dbg)
  );
endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10):
// expected pulses are queued as {edge, run, cont} and matched by a negedge monitor.

module tb_button_conditioner;
  localparam int DB = 4;
  localparam int RP = 10;
  localparam int SW = 16;
  localparam int W  = 34;

  logic          clk;
  logic          rst_n;
  logic          run_raw;
  logic          cont_raw;
  logic [SW-1:0] s_raw;
  logic          run_n;
  logic          cont_n;
  logic          run_pulse;
  logic          cont_pulse;
  logic [SW-1:0] s_sync;
  logic [1:0]    run_state_dbg;
  logic [1:0]    cont_state_dbg;

  logic [31:0]  cyc;
  logic [W-1:0] exp_q[$];
  int           checks;
  int           errors;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES  (RP),
    .SW_WIDTH       (SW)
  ) dut (
    .Clk           (clk),
    .Reset         (rst_n),
    .Run_raw       (run_raw),
    .Continue_raw  (cont_raw),
    .S_raw         (s_raw),
    .Run_n         (run_n),
    .Continue_n    (cont_n),
    .Run_pulse     (run_pulse),
    .Continue_pulse(cont_pulse),
    .S_sync        (s_sync),
    .run_state_dbg (run_state_dbg),
    .cont_state_dbg(cont_state_dbg)
  );

  // clock / edge counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_pulse(input logic [31:0] edge_no, input logic run_b, input logic cont_b);
    exp_q.push_back({edge_no, run_b, cont_b});
  endtask

  // monitor: every observed pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (run_pulse === 1'b1 || cont_pulse === 1'b1)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got edge %0d run=%0b cont=%0b, expected none",
                 cyc, run_pulse, cont_pulse);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (e !== {cyc, run_pulse, cont_pulse}) begin
          errors++;
          $display("FAIL pulse_match: got edge %0d run=%0b cont=%0b, expected edge %0d run=%0b cont=%0b",
                   cyc, run_pulse, cont_pulse, e[W-1:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    logic [31:0] k;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    run_raw  = 1'b1;
    cont_raw = 1'b1;
    s_raw    = '0;

    // reset state
    wait_neg(3);
    check("rst_run_n", 32'(run_n), 32'd1);
    check("rst_cont_n", 32'(cont_n), 32'd1);
    check("rst_pulses", {30'd0, run_pulse, cont_pulse}, 32'd0);
    check("rst_s_sync", 32'(s_sync), 32'd0);
    rst_n = 1'b1;
    wait_neg(3);

    // clean press, hold 20 cycles, then release
    run_raw = 1'b0;
    k = cyc + 1;
    push_pulse(k + 6, 1'b1, 1'b0);
    wait_neg(6);
    check("press_level_before", 32'(run_n), 32'd1);
    wait_neg(1);
    check("press_level_after", 32'(run_n), 32'd0);
    wait_neg(13);
    run_raw = 1'b1;
    wait_neg(6);
    check("release_level_before", 32'(run_n), 32'd0);
    wait_neg(1);
    check("release_level_after", 32'(run_n), 32'd1);
    wait_neg(3);

    // press bounce: 3 low cycles are rejected
    run_raw = 1'b0;
    wait_neg(3);
    run_raw = 1'b1;
    wait_neg(10);
    check("press_bounce_level", 32'(run_n), 32'd1);

    // release bounce: 2 high cycles while pressed are rejected
    run_raw = 1'b0;
    k = cyc + 1;
    push_pulse(k + 6, 1'b1, 1'b0);
    wait_neg(10);
    run_raw = 1'b1;
    wait_neg(2);
    run_raw = 1'b0;
    wait_neg(10);
    check("release_bounce_level", 32'(run_n), 32'd0);
    run_raw = 1'b1;
    wait_neg(10);
    check("release_bounce_final", 32'(run_n), 32'd1);

    // switch synchronizer latency
    s_raw = 16'h0014;
    wait_neg(1);
    check("sw_first_edge", 32'(s_sync), 32'h0000);
    wait_neg(1);
    check("sw_0014", 32'(s_sync), 32'h0014);
    s_raw = 16'hA5C3;
    wait_neg(2);
    check("sw_a5c3", 32'(s_sync), 32'hA5C3);

    // simultaneous presses
    run_raw  = 1'b0;
    cont_raw = 1'b0;
    k = cyc + 1;
    push_pulse(k + 6, 1'b1, 1'b1);
    wait_neg(10);
    check("simul_run_n", 32'(run_n), 32'd0);
    check("simul_cont_n", 32'(cont_n), 32'd0);
    run_raw  = 1'b1;
    cont_raw = 1'b1;
    wait_neg(10);
    check("simul_release", {30'd0, run_n, cont_n}, 32'd3);

    // Continue held 40 cycles
    cont_raw = 1'b0;
    k = cyc + 1;
    push_pulse(k + 6, 1'b0, 1'b1);
`ifdef CONT_AUTOREPEAT_EN
    push_pulse(k + 16, 1'b0, 1'b1);
    push_pulse(k + 26, 1'b0, 1'b1);
    push_pulse(k + 36, 1'b0, 1'b1);
`endif
    wait_neg(40);
    check("hold_cont_n", 32'(cont_n), 32'd0);
    cont_raw = 1'b1;
    wait_neg(12);
    check("hold_release", 32'(cont_n), 32'd1);

    // reset while the Run pulse is high, then a fresh debounce afterwards
    run_raw = 1'b0;
    k = cyc + 1;
    push_pulse(k + 6, 1'b1, 1'b0);
    wait_neg(7);
    check("pre_reset_pulse", 32'(run_pulse), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_run_n", 32'(run_n), 32'd1);
    check("async_rst_pulse", 32'(run_pulse), 32'd0);
    check("async_rst_s_sync", 32'(s_sync), 32'd0);
    wait_neg(1);
    rst_n = 1'b1;
    k = cyc + 1;
    push_pulse(k + 6, 1'b1, 1'b0);
    wait_neg(6);
    check("post_rst_level_before", 32'(run_n), 32'd1);
    wait_neg(1);
    check("post_rst_level_after", 32'(run_n), 32'd0);
    run_raw = 1'b1;
    wait_neg(10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: got %0d unmatched, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end input stage for the lab 6 SLC-3 top level. It conditions the raw DE2 push-buttons (Run, Continue) and the 16 slider switches before they reach the CPU control logic:
- Two-flop synchronization of every input.
- Counter-based debounce of the active-low buttons.
- Clean debounced levels plus single-cycle press pulses, so the downstream state machine sees exactly one Run/Continue event per physical press.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button edge (10 ms at 50 MHz); minimum 2.
- REPEAT_CYCLES, 25000000, Continue auto-repeat period in cycles (used only with CONT_AUTOREPEAT_EN); minimum 2.
- SW_WIDTH, 16, slider switch width.

Ports:
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Run_raw  in  1  raw Run button, active-low (0 = pressed).
- Continue_raw  in  1  raw Continue button, active-low.
- S_raw  in  SW_WIDTH  raw slider switches.
- Run_n  out  1  debounced Run level, active-low.
- Continue_n  out  1  debounced Continue level, active-low.
- Run_pulse  out  1  one-cycle high pulse on each accepted Run press.
- Continue_pulse  out  1  one-cycle high pulse on each accepted Continue press (and on each repeat, if enabled).
- S_sync  out  SW_WIDTH  synchronized switches.

## Operation
- Reset asserted (Reset=0), effective immediately regardless of clock:
  - Button sync flops = 1; switch sync flops = 0.
  - Both FSMs in RELEASED; all counters 0.
  - Run_n=1, Continue_n=1, Run_pulse=0, Continue_pulse=0, S_sync=0.
- Reset mid-debounce or mid-press abandons the operation; no pulse is emitted on reset release.
- Synchronization: each button and each switch bit passes through two flops. The switches have no debounce.
- Each button has an independent FSM with its own counter (width $clog2(max(DEBOUNCE_CYCLES,REPEAT_CYCLES))+1). "sync" below is the second synchronizer flop.
- RELEASED:
  - sync=0 -> PRESS_WAIT, cnt=0.
- PRESS_WAIT:
  - sync=1 -> RELEASED (bounce rejected, no output change).
  - sync=0 and cnt<DEBOUNCE_CYCLES-1 -> cnt+1.
  - sync=0 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED; level_n=0; pulse=1 for exactly one cycle.
- PRESSED:
  - sync=1 -> RELEASE_WAIT, cnt=0.
- RELEASE_WAIT:
  - sync=0 -> PRESSED with no new pulse; level stays 0.
  - sync=1 and cnt==DEBOUNCE_CYCLES-1 -> RELEASED, level_n=1.
  - otherwise cnt+1.
- The Run and Continue FSMs are fully independent. Both pulses may assert in the same cycle.
- Pulses are registered outputs, never combinational from inputs.

## Timing
- Edge k is the first rising edge that samples a raw button low. Then:
  - sync=0 after edge k+1.
  - FSM enters PRESS_WAIT at edge k+2.
  - Run_n falls and Run_pulse rises at edge k+2+DEBOUNCE_CYCLES.
  - Run_pulse falls at the following edge.
- Release latency matches press latency: DEBOUNCE_CYCLES+2 edges from the first raw-high sample to level_n=1.
- A raw glitch shorter than DEBOUNCE_CYCLES cycles (after synchronization) produces no output change.
- Switch latency: S_sync equals S_raw 2 edges after S_raw changes.

## Configuration
- Macro CONT_AUTOREPEAT_EN.
- Defined:
  - While the Continue FSM stays in PRESSED, a repeat counter increments each cycle.
  - When the counter reaches REPEAT_CYCLES-1, Continue_pulse asserts for one cycle and the counter restarts at 0.
  - The counter is cleared on every entry to PRESSED, including re-entry from RELEASE_WAIT.
  - Run never repeats.
- Not defined: exactly one Continue_pulse per debounced press; no repeat logic is synthesized.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10.

- Reset: drive Run_raw=0 long enough to pulse, then Reset=0 mid-press, between edges -> Run_n=1, Run_pulse=0, S_sync=0 immediately. After Reset=1 with Run_raw still 0, a fresh full debounce is required before the next pulse.
- Clean press: Run_raw=0 sampled first at edge 0 and held 20 cycles -> Run_n=0 and a single Run_pulse at edge 6, pulse low at edge 7. Then Run_raw=1 -> Run_n=1 six edges after the first high sample.
- Press bounce: Run_raw=0 for 3 cycles, then 1 -> no Run_pulse, Run_n stays 1.
- Release bounce: while pressed, Run_raw=1 for 2 cycles then 0 -> Run_n stays 0, no second pulse.
- Switches and simultaneity:
  - S_raw=16'h0014 -> S_sync=16'h0014 after 2 edges.
  - Run_raw and Continue_raw fall on the same edge -> both pulses at the same edge.
- Auto-repeat: Continue_raw held low 40 cycles.
  - With CONT_AUTOREPEAT_EN: pulses at edges 6, 16, 26, 36.
  - Without it: a single pulse at edge 6.
